// File: rtl/mem_master_pkg.sv
// Shared types for the native-bus master: access sizes, response codes, FSM states
// and the registered form of an accepted command.
package mem_master_pkg;
   typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2} size_e;
   typedef enum logic [1:0] {ERR_OK = 2'd0, ERR_MISAL = 2'd1, ERR_TMO = 2'd2} err_e;
   typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RSP = 2'd2} state_e;

   typedef struct packed {
      logic       write;
      logic [1:0] size;
      logic       sgn;
      logic [1:0] lane;
   } req_t;
endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store strobes/replication, load extraction and
// sign/zero extension, plus alignment check. Stateless so it can be shared by other ports.
module mem_lane_align
   import mem_master_pkg::*;
(
   input  logic [1:0]  size,
   input  logic        sgn,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata_rep,
   output logic [31:0] rdata_ext,
   output logic        misaligned
);
   logic [7:0]  rd_b;
   logic [15:0] rd_h;

   always_comb begin
      rd_b       = rdata[{addr_lo, 3'b000} +: 8];
      rd_h       = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      misaligned = 1'b0;
      wstrb      = 4'h0;
      wdata_rep  = wdata;
      rdata_ext  = '0;
      case (size)
         SZ_B: begin
            wstrb     = 4'b0001 << addr_lo;
            wdata_rep = {4{wdata[7:0]}};
            rdata_ext = {{24{sgn & rd_b[7]}}, rd_b};
         end
         SZ_H: begin
            misaligned = addr_lo[0];
            wstrb      = 4'b0011 << addr_lo;
            wdata_rep  = {2{wdata[15:0]}};
            rdata_ext  = {{16{sgn & rd_h[15]}}, rd_h};
         end
         SZ_W: begin
            misaligned = (addr_lo != 2'b00);
            wstrb      = 4'hF;
            rdata_ext  = rdata;
         end
         default: misaligned = 1'b1;  // reserved size code
      endcase
   end
endmodule

// File: rtl/mem_bus_master.sv
// Command-port to picorv32 native-bus initiator: one bus cycle per command,
// lane steering via mem_lane_align, optional mem_ready timeout, registered outputs.
module mem_bus_master #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int TMO_W          = 16
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [1:0]  cmd_size,
   input  logic        cmd_signed,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic [1:0]  rsp_err,
   output logic        mem_valid,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata
);
   import mem_master_pkg::*;

   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   state_e            state;
   req_t              req;
   logic [TMO_W-1:0]  tmo_cnt;
   logic              idle;
   logic [1:0]        al_size;
   logic              al_sgn;
   logic [1:0]        al_lane;
   logic [3:0]        al_wstrb;
   logic [31:0]       al_wdata;
   logic [31:0]       al_rdata;
   logic              al_misal;

   // The aligner sees the live command while idle (store lanes, alignment check)
   // and the latched command afterwards (load extraction).
   assign idle    = (state == IDLE);
   assign al_size = idle ? cmd_size        : req.size;
   assign al_sgn  = idle ? cmd_signed      : req.sgn;
   assign al_lane = idle ? cmd_addr[1:0]   : req.lane;

   mem_lane_align u_align (
      .size       (al_size),
      .sgn        (al_sgn),
      .addr_lo    (al_lane),
      .wdata      (cmd_wdata),
      .rdata      (mem_rdata),
      .wstrb      (al_wstrb),
      .wdata_rep  (al_wdata),
      .rdata_ext  (al_rdata),
      .misaligned (al_misal)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         req       <= '0;
         tmo_cnt   <= '0;
         cmd_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= ERR_OK;
         mem_valid <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wstrb <= 4'h0;
      end else begin
         case (state)
            IDLE: if (cmd_valid) begin
               req       <= '{write: cmd_write, size: cmd_size, sgn: cmd_signed,
                              lane: cmd_addr[1:0]};
               tmo_cnt   <= '0;
               cmd_ready <= 1'b0;
               if (al_misal) begin
                  state     <= RSP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= ERR_MISAL;
                  rsp_rdata <= '0;
               end else begin
                  state     <= BUS;
                  mem_valid <= 1'b1;
                  mem_addr  <= {cmd_addr[31:2], 2'b00};
                  mem_wdata <= cmd_write ? al_wdata : '0;
                  mem_wstrb <= cmd_write ? al_wstrb : 4'h0;
               end
            end
            BUS: begin
               // mem_ready is checked first so a same-cycle timeout still completes OK
               if (mem_ready) begin
                  state     <= RSP;
                  mem_valid <= 1'b0;
                  mem_wstrb <= 4'h0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= ERR_OK;
                  rsp_rdata <= req.write ? '0 : al_rdata;
               end else if ((TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST)) begin
                  state     <= RSP;
                  mem_valid <= 1'b0;
                  mem_wstrb <= 4'h0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= ERR_TMO;
                  rsp_rdata <= '0;
               end else begin
                  tmo_cnt <= tmo_cnt + TMO_W'(1);
               end
            end
            RSP: if (rsp_ready) begin
               state     <= IDLE;
               rsp_valid <= 1'b0;
               rsp_rdata <= '0;
               rsp_err   <= ERR_OK;
               cmd_ready <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: wait-state memory responder, response/bus monitors
// feeding queues, and one task per scenario comparing against expected values.
module tb_mem_bus_master;
   typedef struct packed {logic [31:0] rdata; logic [1:0] err;} exp_t;
   typedef struct packed {logic [31:0] addr; logic [3:0] strb; logic [31:0] wdata;} bus_t;

   logic        clk = 1'b0;
   logic        resetn;
   logic        cmd_valid, cmd_ready, cmd_write, cmd_signed;
   logic [1:0]  cmd_size;
   logic [31:0] cmd_addr, cmd_wdata;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_err;
   logic        mem_valid, mem_ready;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;

   logic [31:0] mem [0:255];
   int          wcnt = 0;
   int          lat = 0;
   logic        mem_en = 1'b1;
   int          cyc = 0;
   int          mv_total = 0;
   int          total = 0;
   int          bad = 0;
   int          rd_ptr = 0;
   exp_t        exp_q[$];
   exp_t        rsp_q[$];
   bus_t        bus_q[$];

   mem_bus_master #(.TIMEOUT_CYCLES(8), .TMO_W(16)) dut (
      .clk(clk), .resetn(resetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_size(cmd_size), .cmd_signed(cmd_signed), .cmd_addr(cmd_addr),
      .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err),
      .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // responder: ready after 'lat' wait cycles, combinational read data
   assign mem_ready = mem_valid && mem_en && (wcnt >= lat);
   assign mem_rdata = mem[mem_addr[9:2]];

   always @(posedge clk) begin
      cyc  <= cyc + 1;
      wcnt <= (!mem_valid || mem_ready) ? 0 : wcnt + 1;
      if (!resetn) begin
         for (int i = 0; i < 256; i++) mem[i] <= '0;
      end else if (mem_valid && mem_ready) begin
         for (int j = 0; j < 4; j++)
            if (mem_wstrb[j]) mem[mem_addr[9:2]][8*j +: 8] <= mem_wdata[8*j +: 8];
      end
   end

   always @(negedge clk) begin
      if (mem_valid) mv_total <= mv_total + 1;
      if (resetn && rsp_valid && rsp_ready) rsp_q.push_back(exp_t'({rsp_rdata, rsp_err}));
      if (resetn && mem_valid && mem_ready) bus_q.push_back(bus_t'({mem_addr, mem_wstrb, mem_wdata}));
   end

   task automatic send(input bit push, input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] er, input logic [1:0] ee);
      exp_t e;
      e = '{rdata: er, err: ee};
      if (push) exp_q.push_back(e);
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_write = w; cmd_size = sz; cmd_signed = sg;
      cmd_addr = a; cmd_wdata = d;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (cmd_ready) break;
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (rsp_q.size() == exp_q.size() && cmd_ready) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      resetn = 1'b0;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_size = 2'd0; cmd_signed = 1'b0;
      cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
      total++;
      if ({mem_valid, rsp_valid} !== 2'b00) begin bad++; $display("FAIL reset_valids got=%b exp=00", {mem_valid, rsp_valid}); end
      total++;
      if ({rsp_rdata, rsp_err} !== 34'h0) begin bad++; $display("FAIL reset_rsp got=%h/%0d exp=0/0", rsp_rdata, rsp_err); end
      total++;
      if ({mem_addr, mem_wdata, mem_wstrb} !== 68'h0) begin bad++; $display("FAIL reset_bus got=%h/%h/%h exp=0", mem_addr, mem_wdata, mem_wstrb); end
      @(posedge clk); #1;
      resetn = 1'b1;
      @(negedge clk);
      total++;
      if ({cmd_ready, mem_valid, rsp_valid} !== 3'b100) begin bad++; $display("FAIL post_reset got=%b exp=100", {cmd_ready, mem_valid, rsp_valid}); end
   endtask

   task automatic test_word;
      bit ok;
      int b0;
      bus_t g;
      b0 = bus_q.size();
      lat = 0;
      send(1, 1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 2'd0);
      send(1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 2'd0);
      wait_done(ok);
      total++;
      if (!ok) begin bad++; $display("FAIL word_done got=%0d rsps exp=%0d", rsp_q.size(), exp_q.size()); end
      g = (bus_q.size() > b0) ? bus_q[b0] : '0;
      total++;
      if (g !== bus_t'({32'h100, 4'hF, 32'hDEADBEEF})) begin bad++; $display("FAIL word_store_bus got=%h/%h/%h exp=100/f/deadbeef", g.addr, g.strb, g.wdata); end
      g = (bus_q.size() > b0 + 1) ? bus_q[b0+1] : '1;
      total++;
      if ({g.addr, g.strb} !== {32'h100, 4'h0}) begin bad++; $display("FAIL word_load_bus got=%h/%h exp=100/0", g.addr, g.strb); end
      while (rd_ptr < rsp_q.size()) begin
         total++;
         if (rsp_q[rd_ptr] !== exp_q[rd_ptr]) begin bad++; $display("FAIL word_rsp[%0d] got=%h/%0d exp=%h/%0d", rd_ptr, rsp_q[rd_ptr].rdata, rsp_q[rd_ptr].err, exp_q[rd_ptr].rdata, exp_q[rd_ptr].err); end
         rd_ptr++;
      end
   endtask

   task automatic test_byte;
      bit ok;
      int b0;
      bus_t g;
      b0 = bus_q.size();
      lat = 2;
      send(1, 1'b1, 2'd0, 1'b0, 32'h203, 32'h000000A5, 32'h0, 2'd0);
      send(1, 1'b0, 2'd0, 1'b1, 32'h203, 32'h0, 32'hFFFFFFA5, 2'd0);
      send(1, 1'b0, 2'd0, 1'b0, 32'h203, 32'h0, 32'h000000A5, 2'd0);
      send(1, 1'b0, 2'd1, 1'b1, 32'h202, 32'h0, 32'hFFFFA500, 2'd0);
      send(1, 1'b1, 2'd1, 1'b0, 32'h200, 32'h00001234, 32'h0, 2'd0);
      send(1, 1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 32'hA5001234, 2'd0);
      wait_done(ok);
      total++;
      if (!ok) begin bad++; $display("FAIL byte_done got=%0d rsps exp=%0d", rsp_q.size(), exp_q.size()); end
      g = (bus_q.size() > b0) ? bus_q[b0] : '0;
      total++;
      if (g !== bus_t'({32'h200, 4'b1000, 32'hA5A5A5A5})) begin bad++; $display("FAIL byte_store_bus got=%h/%h/%h exp=200/8/a5a5a5a5", g.addr, g.strb, g.wdata); end
      g = (bus_q.size() > b0 + 4) ? bus_q[b0+4] : '0;
      total++;
      if (g !== bus_t'({32'h200, 4'b0011, 32'h12341234})) begin bad++; $display("FAIL half_store_bus got=%h/%h/%h exp=200/3/12341234", g.addr, g.strb, g.wdata); end
      while (rd_ptr < rsp_q.size()) begin
         total++;
         if (rsp_q[rd_ptr] !== exp_q[rd_ptr]) begin bad++; $display("FAIL byte_rsp[%0d] got=%h/%0d exp=%h/%0d", rd_ptr, rsp_q[rd_ptr].rdata, rsp_q[rd_ptr].err, exp_q[rd_ptr].rdata, exp_q[rd_ptr].err); end
         rd_ptr++;
      end
   endtask

   task automatic test_misaligned;
      bit ok;
      int mv0;
      mv0 = mv_total;
      lat = 0;
      send(1, 1'b0, 2'd1, 1'b0, 32'h101, 32'h0, 32'h0, 2'd1);
      @(negedge clk);
      total++;
      if ({rsp_valid, rsp_err} !== 3'b101) begin bad++; $display("FAIL misal_latency got=%b/%0d exp=1/1", rsp_valid, rsp_err); end
      send(1, 1'b1, 2'd2, 1'b0, 32'h102, 32'h11111111, 32'h0, 2'd1);
      send(1, 1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 32'h0, 2'd1);
      wait_done(ok);
      total++;
      if (!ok) begin bad++; $display("FAIL misal_done got=%0d rsps exp=%0d", rsp_q.size(), exp_q.size()); end
      total++;
      if (mv_total - mv0 !== 0) begin bad++; $display("FAIL misal_no_bus got=%0d mem_valid cycles exp=0", mv_total - mv0); end
      while (rd_ptr < rsp_q.size()) begin
         total++;
         if (rsp_q[rd_ptr] !== exp_q[rd_ptr]) begin bad++; $display("FAIL misal_rsp[%0d] got=%h/%0d exp=%h/%0d", rd_ptr, rsp_q[rd_ptr].rdata, rsp_q[rd_ptr].err, exp_q[rd_ptr].rdata, exp_q[rd_ptr].err); end
         rd_ptr++;
      end
   endtask

   task automatic test_timeout;
      bit ok;
      int mv0;
      mv0 = mv_total;
      mem_en = 1'b0;
      send(1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'h0, 2'd2);
      wait_done(ok);
      mem_en = 1'b1;
      total++;
      if (!ok) begin bad++; $display("FAIL tmo_done got=%0d rsps exp=%0d", rsp_q.size(), exp_q.size()); end
      total++;
      if (mv_total - mv0 !== 8) begin bad++; $display("FAIL tmo_cycles got=%0d exp=8", mv_total - mv0); end
      while (rd_ptr < rsp_q.size()) begin
         total++;
         if (rsp_q[rd_ptr] !== exp_q[rd_ptr]) begin bad++; $display("FAIL tmo_rsp[%0d] got=%h/%0d exp=%h/%0d", rd_ptr, rsp_q[rd_ptr].rdata, rsp_q[rd_ptr].err, exp_q[rd_ptr].rdata, exp_q[rd_ptr].err); end
         rd_ptr++;
      end
   endtask

   task automatic test_backpressure;
      bit ok;
      lat = 1;
      rsp_ready = 1'b0;
      send(1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 2'd0);
      for (int i = 0; i < 50; i++) begin
         if (rsp_valid) break;
         @(negedge clk);
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         total++;
         if ({rsp_valid, rsp_rdata, cmd_ready} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin
            bad++; $display("FAIL bp_hold[%0d] got=%b/%h/%b exp=1/deadbeef/0", k, rsp_valid, rsp_rdata, cmd_ready);
         end
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      total++;
      if ({cmd_ready, rsp_valid} !== 2'b10) begin bad++; $display("FAIL bp_release got=%b exp=10", {cmd_ready, rsp_valid}); end
      wait_done(ok);
      total++;
      if (!ok) begin bad++; $display("FAIL bp_done got=%0d rsps exp=%0d", rsp_q.size(), exp_q.size()); end
      while (rd_ptr < rsp_q.size()) begin
         total++;
         if (rsp_q[rd_ptr] !== exp_q[rd_ptr]) begin bad++; $display("FAIL bp_rsp[%0d] got=%h/%0d exp=%h/%0d", rd_ptr, rsp_q[rd_ptr].rdata, rsp_q[rd_ptr].err, exp_q[rd_ptr].rdata, exp_q[rd_ptr].err); end
         rd_ptr++;
      end
   endtask

   task automatic test_back_to_back;
      bit ok;
      int acc[4];
      int k;
      logic [31:0] a[4];
      logic [1:0]  sz[4];
      logic        sg[4];
      exp_t        e;
      a  = '{32'h100, 32'h200, 32'h202, 32'h203};
      sz = '{2'd2, 2'd2, 2'd1, 2'd0};
      sg = '{1'b0, 1'b0, 1'b0, 1'b1};
      e = '{rdata: 32'hDEADBEEF, err: 2'd0}; exp_q.push_back(e);
      e = '{rdata: 32'hA5001234, err: 2'd0}; exp_q.push_back(e);
      e = '{rdata: 32'h0000A500, err: 2'd0}; exp_q.push_back(e);
      e = '{rdata: 32'hFFFFFFA5, err: 2'd0}; exp_q.push_back(e);
      lat = 0;
      rsp_ready = 1'b1;
      k = 0;
      acc = '{0, 0, 0, 0};
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_write = 1'b0;
      cmd_addr = a[0]; cmd_size = sz[0]; cmd_signed = sg[0];
      for (int i = 0; i < 60 && k < 4; i++) begin
         @(negedge clk);
         if (cmd_ready) begin
            acc[k] = cyc;
            k++;
            @(posedge clk); #1;
            if (k < 4) begin
               cmd_addr = a[k]; cmd_size = sz[k]; cmd_signed = sg[k];
            end else begin
               cmd_valid = 1'b0;
            end
         end
      end
      cmd_valid = 1'b0;
      for (int j = 1; j < 4; j++) begin
         total++;
         if (acc[j] - acc[j-1] !== 3) begin bad++; $display("FAIL b2b_spacing[%0d] got=%0d exp=3", j, acc[j] - acc[j-1]); end
      end
      wait_done(ok);
      total++;
      if (!ok) begin bad++; $display("FAIL b2b_done got=%0d rsps exp=%0d", rsp_q.size(), exp_q.size()); end
      while (rd_ptr < rsp_q.size()) begin
         total++;
         if (rsp_q[rd_ptr] !== exp_q[rd_ptr]) begin bad++; $display("FAIL b2b_rsp[%0d] got=%h/%0d exp=%h/%0d", rd_ptr, rsp_q[rd_ptr].rdata, rsp_q[rd_ptr].err, exp_q[rd_ptr].rdata, exp_q[rd_ptr].err); end
         rd_ptr++;
      end
   endtask

   task automatic test_reset_mid;
      bit ok;
      int b0;
      bus_t g;
      mem_en = 1'b0;
      send(0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'h0, 2'd0);
      for (int i = 0; i < 20; i++) begin
         if (mem_valid) break;
         @(negedge clk);
      end
      total++;
      if (mem_valid !== 1'b1) begin bad++; $display("FAIL mid_bus_active got=%b exp=1", mem_valid); end
      #1 resetn = 1'b0;
      #1;
      total++;
      if ({mem_valid, rsp_valid, cmd_ready} !== 3'b001) begin bad++; $display("FAIL mid_reset_drop got=%b exp=001", {mem_valid, rsp_valid, cmd_ready}); end
      @(posedge clk); #1;
      resetn = 1'b1;
      mem_en = 1'b1;
      b0 = bus_q.size();
      send(1, 1'b1, 2'd2, 1'b0, 32'h44, 32'h12345678, 32'h0, 2'd0);
      send(1, 1'b1, 2'd1, 1'b0, 32'h46, 32'h0000BEEF, 32'h0, 2'd0);
      send(1, 1'b0, 2'd2, 1'b0, 32'h44, 32'h0, 32'hBEEF5678, 2'd0);
      wait_done(ok);
      total++;
      if (!ok) begin bad++; $display("FAIL mid_done got=%0d rsps exp=%0d", rsp_q.size(), exp_q.size()); end
      g = (bus_q.size() > b0 + 1) ? bus_q[b0+1] : '0;
      total++;
      if (g !== bus_t'({32'h44, 4'b1100, 32'hBEEFBEEF})) begin bad++; $display("FAIL mid_half_bus got=%h/%h/%h exp=44/c/beefbeef", g.addr, g.strb, g.wdata); end
      while (rd_ptr < rsp_q.size()) begin
         total++;
         if (rsp_q[rd_ptr] !== exp_q[rd_ptr]) begin bad++; $display("FAIL mid_rsp[%0d] got=%h/%0d exp=%h/%0d", rd_ptr, rsp_q[rd_ptr].rdata, rsp_q[rd_ptr].err, exp_q[rd_ptr].rdata, exp_q[rd_ptr].err); end
         rd_ptr++;
      end
   endtask

   initial begin
      test_reset();
      test_word();
      test_byte();
      test_misaligned();
      test_timeout();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
endmodule
